gecko_iterative_shifter: RTL
============================

Name: gecko_iterative_shifter

Overview:
- Multi-cycle barrel-shift unit for the gecko execute path.
- Shifts by at most STEP_SIZE bit positions per cycle, so large shift amounts are not built as one wide combinational shifter.
- Supports four shift types: left logical, right logical, right arithmetic, and a new rotate-left mode.
- Width is parametrised; a tag is passed through; a flush aborts the operation for speculative kills.

Parameters:
- DATA_WIDTH, 32, operand/result width; power of two, ≥8.
- STEP_SIZE, 4, maximum bit positions shifted per cycle; power of two, 1..DATA_WIDTH/2.
- ID_WIDTH, 3, width of the pass-through tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous abort of any in-flight or completed-but-unconsumed operation.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_value  in  DATA_WIDTH  operand.
- cmd_amount  in  $clog2(DATA_WIDTH)  shift amount.
- cmd_type  in  2  shift type: 0=LL, 1=RL, 2=RA, 3=ROL (rotate left).
- cmd_id  in  ID_WIDTH  tag.
- result_valid  out  1  result valid.
- result_ready  in  1  result consumed when valid&&ready.
- result_value  out  DATA_WIDTH  shifted value.
- result_id  out  ID_WIDTH  tag of the accepted command.

Behaviour:
- States: IDLE, SHIFT, DONE. Reset and flush both enter IDLE.
- Reset values:
  - state=IDLE, cmd_ready=1, result_valid=0, result_value=0, result_id=0.
  - Internal remaining-count, type and value registers are cleared.
- cmd_ready is 1 only in IDLE. The unit holds at most one operation.
- IDLE, on cmd_valid&&cmd_ready:
  - Capture value, type, id, and remaining=cmd_amount.
  - Go to SHIFT if amount≠0, else go to DONE.
- SHIFT, each cycle:
  - step = min(remaining, STEP_SIZE).
  - Apply step to the value register: LL shifts in 0s; RL shifts in 0s from the MSB; RA replicates the original MSB; ROL wraps MSBs into LSBs.
  - remaining -= step.
  - Go to DONE when the new remaining value is 0.
- Step width:
  - Only steps of 0..STEP_SIZE are implemented; no full-width shifter exists.
  - The RA fill bit is the value register's MSB at each step, which equals the original sign bit.
- Latency:
  - Command accepted at cycle 0; result_valid rises at cycle 1+ceil(amount/STEP_SIZE).
  - Amount 0 gives result_valid at cycle 1.
- DONE:
  - result_valid=1; result_value and result_id are stable.
  - Moves to IDLE on result_ready. A new command cannot be accepted in that same cycle; cmd_ready rises the following cycle.
  - Holds all outputs indefinitely while result_ready=0.
- flush:
  - Has priority over all handshakes in every state.
  - Next state is IDLE; result_valid=0 the next cycle. Any command presented with cmd_valid in the flush cycle is not accepted.
  - result_value/result_id need not clear; only the valid flag matters.
- rst mid-operation: immediate return to the reset values regardless of clk.
- Arithmetic: remaining is $clog2(DATA_WIDTH) bits and never underflows, because step ≤ remaining.
- Outputs are registered; there is no combinational path from cmd_* to result_*.
- No illegal encodings exist: cmd_type uses all four codes.

Test Plan (DATA_WIDTH=32, STEP_SIZE=4):
1. LL, value 0x0000_0001, amount 5, id 2 → two SHIFT cycles (4 then 1); result_valid at cycle 3; result_value 0x0000_0020; result_id 2.
2. RA, value 0x8000_0000, amount 31 → 8 SHIFT cycles; valid at cycle 9; value 0xFFFF_FFFF. Repeat with RL → 0x0000_0001.
3. ROL, value 0x8000_0001, amount 4 → valid at cycle 2; value 0x0000_0018. ROL by 31 of 0x0000_0001 → 0x8000_0000.
4. Amount 0, value 0xDEAD_BEEF, then hold result_ready=0 for 3 cycles → valid at cycle 1; value/id stable; cmd_ready=0 throughout. After result_ready pulses, cmd_ready=1 the next cycle.
5. Flush on cycle 2 of an amount-20 op, with cmd_valid also asserted that cycle → result_valid never asserts for that op; the concurrent command is not accepted; cmd_ready=1 at cycle 3. A new LL 0x1 by 1 then returns 0x2 correctly.
6. Assert rst asynchronously mid-SHIFT and also in DONE → outputs return to reset values without a clock edge; the next command completes normally. Randomised compare against a reference model over all types and amounts 0..31.

Source files
------------

// File: rtl/gecko_iterative_shifter.sv
// Multi-cycle shift unit: applies at most STEP_SIZE bit positions per cycle
// for LL/RL/RA/ROL shifts. Holds one operation; passes an id tag through;
// flush aborts any in-flight or unconsumed result.
module gecko_iterative_shifter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STEP_SIZE  = 4,
    parameter int unsigned ID_WIDTH   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [DATA_WIDTH-1:0]         cmd_value,
    input  logic [$clog2(DATA_WIDTH)-1:0] cmd_amount,
    input  logic [1:0]                    cmd_type,
    input  logic [ID_WIDTH-1:0]           cmd_id,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [DATA_WIDTH-1:0]         result_value,
    output logic [ID_WIDTH-1:0]           result_id
);

    localparam int unsigned AmtWidth = $clog2(DATA_WIDTH);
    localparam logic [AmtWidth-1:0] StepMax = AmtWidth'(STEP_SIZE);

    localparam logic [1:0] TypeLl  = 2'd0;
    localparam logic [1:0] TypeRl  = 2'd1;
    localparam logic [1:0] TypeRa  = 2'd2;
    localparam logic [1:0] TypeRol = 2'd3;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [1:0]            type_q, type_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [AmtWidth-1:0]   remaining_q, remaining_d;

    logic [AmtWidth-1:0]   step;
    logic [AmtWidth-1:0]   remaining_next;
    logic [DATA_WIDTH-1:0] shifted;

    // Step size and one bounded shift of the value register; step <= remaining
    // so the subtraction never underflows.
    always_comb begin
        step = (remaining_q > StepMax) ? StepMax : remaining_q;
        remaining_next = remaining_q - step;
        shifted = value_q;
        // Small mux over the legal step amounts 1..STEP_SIZE (0 leaves value).
        for (int unsigned k = 1; k <= STEP_SIZE; k++) begin
            if (step == AmtWidth'(k)) begin
                case (type_q)
                    TypeLl:  shifted = value_q << k;
                    TypeRl:  shifted = value_q >> k;
                    // MSB of the register is still the original sign bit.
                    TypeRa:  shifted = $signed(value_q) >>> k;
                    TypeRol: shifted = (value_q << k) | (value_q >> (DATA_WIDTH - k));
                    default: shifted = value_q;
                endcase
            end
        end
    end

    // Next-state logic; flush overrides every handshake.
    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        type_d      = type_q;
        id_d        = id_q;
        remaining_d = remaining_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        value_d     = cmd_value;
                        type_d      = cmd_type;
                        id_d        = cmd_id;
                        remaining_d = cmd_amount;
                        state_d     = (cmd_amount == '0) ? StDone : StShift;
                    end
                end
                StShift: begin
                    value_d     = shifted;
                    remaining_d = remaining_next;
                    if (remaining_next == '0) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            value_q     <= '0;
            type_q      <= '0;
            id_q        <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            type_q      <= type_d;
            id_q        <= id_d;
            remaining_q <= remaining_d;
        end
    end

    assign cmd_ready    = (state_q == StIdle);
    assign result_valid = (state_q == StDone);
    assign result_value = value_q;
    assign result_id    = id_q;

endmodule
